// File: rtl/traffic_phase_controller.sv
// Traffic phase controller: one green approach at a time, GREEN -> YELLOW -> ALLRED
// cycling with demand-driven road selection and emergency preemption.
module traffic_phase_controller #(
  parameter int N_ROADS   = 4,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_ROADS-1:0]           car_det,
  input  logic                         emergency,
  input  logic [$clog2(N_ROADS)-1:0]   emerg_road,
  output logic [3*N_ROADS-1:0]         light,
  output logic [$clog2(N_ROADS)-1:0]   active_road,
  output logic                         phase_start
);

  localparam int RW = $clog2(N_ROADS);
  localparam logic [CNT_W-1:0] G_MIN_LIM = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] G_MAX_LIM = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_LIM     = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] A_LIM     = CNT_W'(ALLRED_T - 1);

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] timer, timer_d, timer_inc;
  logic [RW-1:0]    road_d, emerg_sel, next_road;
  logic             other_dem, found;

  // Field per road is {green, yellow, red}; every road not owning the phase is red.
  function automatic logic [3*N_ROADS-1:0] decode(input state_t s, input logic [RW-1:0] r);
    logic [3*N_ROADS-1:0] l;
    l = '0;
    for (int unsigned i = 0; i < N_ROADS; i++) begin
      if (RW'(i) == r && s == GREEN)       l[3*i +: 3] = 3'b100;
      else if (RW'(i) == r && s == YELLOW) l[3*i +: 3] = 3'b010;
      else                                 l[3*i +: 3] = 3'b001;
    end
    return l;
  endfunction

  always_comb begin
    emerg_sel = (int'(emerg_road) >= N_ROADS) ? '0 : emerg_road;
    timer_inc = (timer == '1) ? timer : timer + CNT_W'(1);

    other_dem = 1'b0;
    for (int unsigned i = 0; i < N_ROADS; i++) begin
      if (RW'(i) != active_road) other_dem = other_dem | car_det[i];
    end

    // Round-robin search starting after the active road; active road is checked last.
    next_road = '0;
    found     = 1'b0;
    for (int unsigned k = 1; k <= N_ROADS; k++) begin
      if (!found && car_det[(int'(active_road) + int'(k)) % N_ROADS]) begin
        next_road = RW'((int'(active_road) + int'(k)) % N_ROADS);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    road_d  = active_road;
    case (state)
      GREEN: begin
        if (emergency) begin
          if (emerg_sel != active_road) state_d = YELLOW;
        end else if (other_dem && (timer >= G_MIN_LIM || timer >= G_MAX_LIM)) begin
          state_d = YELLOW;
        end
      end
      YELLOW: begin
        if (timer >= Y_LIM) state_d = ALLRED;
      end
      ALLRED: begin
        if (timer >= A_LIM) begin
          state_d = GREEN;
          road_d  = emergency ? emerg_sel : next_road;
        end
      end
      default: state_d = GREEN;
    endcase
    timer_d = (state_d != state) ? '0 : timer_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= GREEN;
      active_road <= '0;
      timer       <= '0;
      phase_start <= 1'b0;
      light       <= decode(GREEN, '0);
    end else begin
      state       <= state_d;
      active_road <= road_d;
      timer       <= timer_d;
      phase_start <= (state == ALLRED) && (state_d == GREEN);
      light       <= decode(state_d, road_d);
    end
  end

endmodule

// File: doc/traffic_phase_controller.md
TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

Interface
REQ-001 Parameter N_ROADS, default 4: number of approaches, legal range 2..8.
REQ-002 Parameter CNT_W, default 8: phase timer width.
REQ-003 Parameter GREEN_MIN, default 4: minimum green cycles; GREEN_MAX, default 10: maximum green cycles when another road has demand (GREEN_MIN <= GREEN_MAX < 2^CNT_W).
REQ-004 Parameter YELLOW_T, default 2: yellow cycles; ALLRED_T, default 1: all-red cycles; both >= 1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 car_det  input  N_ROADS  per-road vehicle demand, level-sensitive, sampled every cycle.
REQ-008 emergency  input  1  preemption request, level-sensitive.
REQ-009 emerg_road  input  $clog2(N_ROADS)  road to serve during preemption; values >= N_ROADS treated as 0.
REQ-010 light  output  3*N_ROADS  per road r, bits [3r+2:3r] = {green, yellow, red}, one-hot.
REQ-011 active_road  output  $clog2(N_ROADS)  road currently owning green/yellow.
REQ-012 phase_start  output  1  one-cycle pulse on the first green cycle of each new phase.

Function
REQ-013 FSM states GREEN, YELLOW, ALLRED, binary or one-hot encoded, registered.
REQ-014 Timer: resets to 0 on every state entry, increments by 1 per cycle, saturates at 2^CNT_W-1.
REQ-015 other_dem = OR of car_det excluding active_road.
REQ-016 GREEN -> YELLOW when timer >= GREEN_MIN-1 and other_dem = 1, or when timer >= GREEN_MAX-1 and other_dem = 1; otherwise remain GREEN (rest on green, no upper bound without demand).
REQ-017 GREEN -> YELLOW immediately, ignoring GREEN_MIN, when emergency = 1 and emerg_road != active_road.
REQ-018 GREEN with emergency = 1 and emerg_road = active_road: remain GREEN regardless of demand or timer.
REQ-019 YELLOW lasts exactly YELLOW_T cycles, then ALLRED; emergency cannot shorten it.
REQ-020 ALLRED lasts exactly ALLRED_T cycles, then GREEN on next road.
REQ-021 Next-road selection is made on the last ALLRED cycle: if emergency = 1, emerg_road; else first road with car_det = 1 searching active_road+1, +2, ... wrapping modulo N_ROADS, active_road itself searched last; if no demand, road 0.
REQ-022 active_road updates on ALLRED -> GREEN edge only; stays constant through GREEN, YELLOW, ALLRED.
REQ-023 Outputs are Moore, registered-state decoded: active road shows green in GREEN, yellow in YELLOW; all other roads red; all roads red in ALLRED.
REQ-024 Exactly one bit of each road's 3-bit field is set in every cycle, including reset.
REQ-025 phase_start = 1 only in the first GREEN cycle after ALLRED; 0 otherwise.

Reset
REQ-026 rst = 1 at a clock edge forces state GREEN, active_road 0, timer 0, phase_start 0, in any state mid-phase.
REQ-027 While rst = 1 and the following cycle: light shows road 0 green, all others red.
REQ-028 No phase_start pulse is produced by leaving reset.

Verification
REQ-029 Defaults, reset, car_det=0000 for 50 cycles -> road 0 green continuously, phase_start never 1.
REQ-030 Road 0 green at timer 0, car_det=0100 held -> yellow on road 0 after 4 green cycles, 2 yellow, 1 all-red, road 2 green with phase_start pulse; active_road=2.
REQ-031 Road 1 green, car_det=1111 held -> service order 2,3,0,1 with green of exactly 4 cycles each.
REQ-032 Road 0 green at timer 1, emergency=1, emerg_road=3 -> yellow next cycle, then 2 yellow, 1 all-red, road 3 green; stays green while emergency held despite car_det=1111.
REQ-033 Road 2 in YELLOW, rst pulsed 1 cycle -> next cycle road 0 green, others red, timer 0.
REQ-034 car_det=0010 drops to 0000 during road 0 YELLOW -> after all-red, road 0 selected (no demand), phase_start pulses.
